// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: shared types and constants for the BCD seven-segment scanner.
//   state_t          scan slot sequence S_SHOW0 -> S_GAP0 -> S_SHOW1 -> S_GAP1
//   SEG_0..SEG_9     active-high segment codes, bit0 = a .. bit6 = g, bit7 = dp
//   SEG_DASH/SEG_OFF dash for non-decimal nibbles, all segments off
//   DIG_OFF          active-low digit enables with both digits off
package bcd_seg_pkg;

  typedef enum logic [1:0] {
    S_SHOW0 = 2'd0,
    S_GAP0  = 2'd1,
    S_SHOW1 = 2'd2,
    S_GAP1  = 2'd3
  } state_t;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;
  localparam logic [1:0] DIG_OFF  = 2'b11;

  // True for nibbles that are not a decimal digit.
  function automatic logic nib_bad(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_scan_if: display-side bundle of the BCD scanner.
//   bcd_in[7:0]   packed BCD, [7:4] tens (DK1), [3:0] units (DK0)
//   dp_mask[1:0]  decimal-point enables, [1] DK1, [0] DK0
//   blank         forces all digits off while high
//   seg[7:0]      active-high segments, [7] = dp
//   dig_sel[1:0]  active-low digit enables, [1] DK1, [0] DK0
//   frame_start   one-cycle pulse on entry to the tens slot
//   bad_digit     sticky non-decimal-nibble flag
// Modports: master drives the count and observes the display, slave is the scanner.
interface bcd_seg_scan_if;
  logic [7:0] bcd_in;
  logic [1:0] dp_mask;
  logic       blank;
  logic [7:0] seg;
  logic [1:0] dig_sel;
  logic       frame_start;
  logic       bad_digit;

  modport master (
    output bcd_in, dp_mask, blank,
    input  seg, dig_sel, frame_start, bad_digit
  );

  modport slave (
    input  bcd_in, dp_mask, blank,
    output seg, dig_sel, frame_start, bad_digit
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble to seven-segment decode.
//   nib[3:0]   input digit
//   seg7[6:0]  active-high segments a..g (bit0 = a); A-F show a dash
//   invalid    high when nib is not a decimal digit
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7,
  output logic       invalid
);

  logic [7:0] code;

  always_comb begin
    code = SEG_DASH;
    unique case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
  end

  assign seg7    = code[6:0];
  assign invalid = nib_bad(nib);

endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: two-digit multiplexed seven-segment driver for a packed BCD count.
// The count is snapshotted once per frame (on entry to the tens slot) so a digit
// pair never tears; slots are separated by blanking gaps to suppress ghosting.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_seg_scan_if.slave (bcd_in, dp_mask, blank in; seg, dig_sel,
//          frame_start, bad_digit out)
// Parameters: SHOW_CYC cycles per lit slot, GAP_CYC cycles per blank gap (both >= 1).
// Build option: define LEAD_ZERO_BLANK_EN to blank the tens slot when tens == 0.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int SHOW_CYC = 49_000,
  parameter int GAP_CYC  = 1_000
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_seg_scan_if.slave  bus
);

  localparam int MAX_CYC = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    digits, digits_nxt;
  logic [1:0]    dp, dp_nxt;
  logic          slot_last, snap;
  logic [3:0]    dec_nib;
  logic [6:0]    dec_seg7;
  logic          dec_bad;
  logic [7:0]    seg_nxt;
  logic [1:0]    dig_nxt;

  bcd_to_seg7 u_dec (
    .nib     (dec_nib),
    .seg7    (dec_seg7),
    .invalid (dec_bad)
  );

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    slot_last = (state == S_SHOW0 || state == S_SHOW1) ? (timer == SHOW_LAST)
                                                      : (timer == GAP_LAST);
    if (slot_last) begin
      timer_nxt = '0;
      unique case (state)
        S_SHOW0: state_nxt = S_GAP0;
        S_GAP0:  state_nxt = S_SHOW1;
        S_SHOW1: state_nxt = S_GAP1;
        default: state_nxt = S_SHOW0;
      endcase
    end
    snap = slot_last && (state == S_GAP1);

    // Outputs are registered from the post-edge view, so the snapshot edge
    // already decodes the freshly sampled input rather than the stale latch.
    digits_nxt = snap ? bus.bcd_in  : digits;
    dp_nxt     = snap ? bus.dp_mask : dp;
    dec_nib    = (state_nxt == S_SHOW0) ? digits_nxt[7:4] : digits_nxt[3:0];

    seg_nxt = SEG_OFF;
    dig_nxt = DIG_OFF;
    if (state_nxt == S_SHOW0) begin
      seg_nxt = {dp_nxt[1], dec_seg7};
      dig_nxt = 2'b01;
`ifdef LEAD_ZERO_BLANK_EN
      if (digits_nxt[7:4] == 4'd0) begin
        seg_nxt = SEG_OFF;
        dig_nxt = DIG_OFF;
      end
`endif
    end else if (state_nxt == S_SHOW1) begin
      seg_nxt = {dp_nxt[0], dec_seg7};
      dig_nxt = 2'b10;
    end
    if (bus.blank) begin
      seg_nxt = SEG_OFF;
      dig_nxt = DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_GAP1;
      timer           <= '0;
      digits          <= 8'h00;
      dp              <= 2'b00;
      bus.seg         <= SEG_OFF;
      bus.dig_sel     <= DIG_OFF;
      bus.frame_start <= 1'b0;
      bus.bad_digit   <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      digits          <= digits_nxt;
      dp              <= dp_nxt;
      bus.seg         <= seg_nxt;
      bus.dig_sel     <= dig_nxt;
      bus.frame_start <= snap;
      // On the snapshot edge the decoder is looking at the new tens nibble,
      // so its invalid flag covers tens; units is checked directly.
      if (snap && (dec_bad || nib_bad(bus.bcd_in[3:0])))
        bus.bad_digit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int FRAME = 2 * (SHOW + GAP);

  typedef struct packed {
    logic [7:0] seg;
    logic [1:0] dig;
    logic       fs;
    logic       bad;
  } exp_t;

  logic clk;
  logic rst_n;
  bcd_seg_scan_if bus ();

  bcd_seg_scan #(.SHOW_CYC(SHOW), .GAP_CYC(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // reference model state
  int         m_k;
  int         m_j;
  logic [7:0] m_dig;
  logic [1:0] m_dp;
  logic       m_bad;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F;
      4'h1: return 8'h06;
      4'h2: return 8'h5B;
      4'h3: return 8'h4F;
      4'h4: return 8'h66;
      4'h5: return 8'h6D;
      4'h6: return 8'h7D;
      4'h7: return 8'h07;
      4'h8: return 8'h7F;
      4'h9: return 8'h6F;
      default: return 8'h40;
    endcase
  endfunction

  task automatic model_reset();
    m_k = 0; m_j = -1; m_dig = 8'h00; m_dp = 2'b00; m_bad = 1'b0;
  endtask

  // Evaluated at a rising edge with the inputs as the DUT samples them.
  task automatic model_step();
    exp_t e;
    e = '{seg: 8'h00, dig: 2'b11, fs: 1'b0, bad: m_bad};
    m_k++;
    m_j = (m_k >= GAP) ? (m_k - GAP) % FRAME : -1;
    if (m_j == 0) begin
      m_dig = bus.bcd_in;
      m_dp  = bus.dp_mask;
      if (bus.bcd_in[7:4] > 4'd9 || bus.bcd_in[3:0] > 4'd9) m_bad = 1'b1;
      e.fs = 1'b1;
    end
    e.bad = m_bad;
    if (m_j >= 0 && m_j < SHOW) begin
      e.seg = {m_dp[1], ref_seg(m_dig[7:4])[6:0]};
      e.dig = 2'b01;
`ifdef LEAD_ZERO_BLANK_EN
      if (m_dig[7:4] == 4'd0) begin
        e.seg = 8'h00;
        e.dig = 2'b11;
      end
`endif
    end else if (m_j >= SHOW + GAP && m_j < 2 * SHOW + GAP) begin
      e.seg = {m_dp[0], ref_seg(m_dig[3:0])[6:0]};
      e.dig = 2'b10;
    end
    if (bus.blank) begin
      e.seg = 8'h00;
      e.dig = 2'b11;
    end
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("seg",         {24'd0, bus.seg},         {24'd0, e.seg});
      chk("dig_sel",     {30'd0, bus.dig_sel},     {30'd0, e.dig});
      chk("frame_start", {31'd0, bus.frame_start}, {31'd0, e.fs});
      chk("bad_digit",   {31'd0, bus.bad_digit},   {31'd0, e.bad});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_out();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_j(input int target);
    int n;
    n = 0;
    while (m_j != target && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (m_j != target) chk("wait_slot_timeout", m_j, target);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, {24'd0, bus.seg},         32'h00);
    chk({tag, "_dig"}, {30'd0, bus.dig_sel},     32'h3);
    chk({tag, "_fs"},  {31'd0, bus.frame_start}, 32'h0);
    chk({tag, "_bad"}, {31'd0, bus.bad_digit},   32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.bcd_in  = 8'h27;
    bus.dp_mask = 2'b00;
    bus.blank   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // first frame of "27", then change mid-units slot
    run(14);
    bus.bcd_in = 8'h12;
    wait_j(0);
    wait_j(7);
    bus.bcd_in = 8'h13;
    run(2 * FRAME);

    // count wrap sequence
    bus.bcd_in = 8'h29; run(FRAME);
    bus.bcd_in = 8'h30; run(FRAME);
    bus.bcd_in = 8'h00; run(FRAME);

    // non-decimal nibble, then sticky flag
    bus.bcd_in = 8'h3C; run(2 * FRAME);
    bus.bcd_in = 8'h05; run(2 * FRAME);

    // blank mid tens slot
    wait_j(1);
    bus.blank = 1'b1; run(10);
    bus.blank = 1'b0; run(2 * FRAME);

    // decimal points
    bus.bcd_in = 8'h48; bus.dp_mask = 2'b10; run(FRAME);
    bus.dp_mask = 2'b01; run(FRAME);
    bus.dp_mask = 2'b00;

    // asynchronous reset mid units slot
    wait_j(7);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("mid_rst_hold");
    model_reset();
    sb_q.delete();
    bus.bcd_in = 8'h05;
    rst_n = 1'b1;
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
